// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch sequencer.
// Condition codes, FSM states and the flag bundle.
package branch_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int CNT_W_DEF       = 16;
  localparam int LINK_OFFSET_DEF = 8;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DSLOT   = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval_unit.sv
// Combinational branch condition evaluator.
// Unlisted codes and NV never evaluate true.
module cond_eval_unit
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_eval
);

  // decode condition against committed flags
  always_comb begin
    cond_eval = 1'b0;
    case (cond)
      COND_EQ: cond_eval = flags.z;
      COND_NE: cond_eval = ~flags.z;
      COND_CS: cond_eval = flags.c;
      COND_CC: cond_eval = ~flags.c;
      COND_MI: cond_eval = flags.n;
      COND_PL: cond_eval = ~flags.n;
      COND_VS: cond_eval = flags.v;
      COND_VC: cond_eval = ~flags.v;
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: flag register, branch latch,
// one-cycle resolution, delay-slot guard, stats.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              B_in,
  input  logic              BL_in,
  input  logic [3:0]        I_Cond_in,
  input  logic              flags_we_in,
  input  logic              Z_in,
  input  logic              N_in,
  input  logic              C_in,
  input  logic              V_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target_in,
  output logic              pc_sel_out,
  output logic [ADDR_W-1:0] target_out,
  output logic              flush_out,
  output logic              link_we_out,
  output logic [ADDR_W-1:0] link_addr_out,
  output logic              busy_out,
  output logic              ds_branch_err_out,
  output logic [CNT_W-1:0]  branch_cnt_out,
  output logic [CNT_W-1:0]  taken_cnt_out
);

  state_t            state_q;
  state_t            state_d;
  flags_t            flags_q;
  logic [3:0]        cond_q;
  logic              bl_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] link_q;
  logic [CNT_W-1:0]  branch_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic br_req;
  logic taken;
  logic latch_en;
  logic cnt_br;
  logic cnt_tk;

  assign br_req = B_in | BL_in;

  cond_eval_unit u_cond (
    .cond      (cond_q),
    .flags     (flags_q),
    .cond_eval (taken)
  );

  // architectural flags, updated by EX in any state
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (flags_we_in && !stall_in) begin
      flags_q <= '{z: Z_in, n: N_in, c: C_in, v: V_in};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and single-cycle strobes
  always_comb begin
    state_d           = state_q;
    latch_en          = 1'b0;
    cnt_br            = 1'b0;
    cnt_tk            = 1'b0;
    pc_sel_out        = 1'b0;
    flush_out         = 1'b0;
    link_we_out       = 1'b0;
    busy_out          = 1'b0;
    ds_branch_err_out = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (br_req && !stall_in) begin
            latch_en = 1'b1;
            state_d  = RESOLVE;
          end
        end
        RESOLVE: begin
          busy_out = 1'b1;
          if (!stall_in) begin
            cnt_br = 1'b1;
            if (taken) begin
              cnt_tk      = 1'b1;
              pc_sel_out  = 1'b1;
              flush_out   = 1'b1;
              link_we_out = bl_q;
              state_d     = DSLOT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DSLOT: begin
          if (!stall_in) begin
            ds_branch_err_out = br_req;
            state_d           = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // capture the ID branch when accepted in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q   <= '0;
      bl_q     <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
    end else if (latch_en) begin
      cond_q   <= I_Cond_in;
      bl_q     <= BL_in;
      target_q <= target_in;
      link_q   <= pc_in + ADDR_W'(LINK_OFFSET);
    end
  end

  // wrapping branch and taken statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      if (cnt_br) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (cnt_tk) taken_cnt_q  <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign target_out     = target_q;
  assign link_addr_out  = link_q;
  assign branch_cnt_out = branch_cnt_q;
  assign taken_cnt_out  = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
// Per-cycle vector table plus stall and reset sequences.
module tb_branch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        B_in;
  logic        BL_in;
  logic [3:0]  I_Cond_in;
  logic        flags_we_in;
  logic        Z_in, N_in, C_in, V_in;
  logic [31:0] pc_in;
  logic [31:0] target_in;
  logic        pc_sel_out;
  logic [31:0] target_out;
  logic        flush_out;
  logic        link_we_out;
  logic [31:0] link_addr_out;
  logic        busy_out;
  logic        ds_branch_err_out;
  logic [15:0] branch_cnt_out;
  logic [15:0] taken_cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  branch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .stall_in          (stall_in),
    .B_in              (B_in),
    .BL_in             (BL_in),
    .I_Cond_in         (I_Cond_in),
    .flags_we_in       (flags_we_in),
    .Z_in              (Z_in),
    .N_in              (N_in),
    .C_in              (C_in),
    .V_in              (V_in),
    .pc_in             (pc_in),
    .target_in         (target_in),
    .pc_sel_out        (pc_sel_out),
    .target_out        (target_out),
    .flush_out         (flush_out),
    .link_we_out       (link_we_out),
    .link_addr_out     (link_addr_out),
    .busy_out          (busy_out),
    .ds_branch_err_out (ds_branch_err_out),
    .branch_cnt_out    (branch_cnt_out),
    .taken_cnt_out     (taken_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        b;
    logic        bl;
    logic [3:0]  cond;
    logic        fwe;
    logic [3:0]  zncv;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [4:0]  e_str;
    logic [31:0] e_tgt;
    logic [31:0] e_link;
    logic [15:0] e_bc;
    logic [15:0] e_tc;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic b, input logic bl,
                       input logic [3:0] cond, input logic fwe,
                       input logic [3:0] zncv, input logic [31:0] pc,
                       input logic [31:0] tgt);
    stall_in    = st;
    B_in        = b;
    BL_in       = bl;
    I_Cond_in   = cond;
    flags_we_in = fwe;
    {Z_in, N_in, C_in, V_in} = zncv;
    pc_in       = pc;
    target_in   = tgt;
  endtask

  function automatic logic [4:0] strobes();
    return {pc_sel_out, flush_out, link_we_out, busy_out, ds_branch_err_out};
  endfunction

  task automatic check_all(input string tag, input int row,
                           input logic [4:0] s, input logic [31:0] t,
                           input logic [31:0] l, input logic [15:0] bc,
                           input logic [15:0] tc);
    check({tag, ".strobes"}, row, 32'(strobes()), 32'(s));
    check({tag, ".target"}, row, target_out, t);
    check({tag, ".link"}, row, link_addr_out, l);
    check({tag, ".bcnt"}, row, 32'(branch_cnt_out), 32'(bc));
    check({tag, ".tcnt"}, row, 32'(taken_cnt_out), 32'(tc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // strobes: {pc_sel, flush, link_we, busy, err}
    tbl[0]  = '{0,1,0,4'd0, 1,4'b1000,32'h10, 32'h100,5'b00000,32'h0,  32'h0,  16'd0,16'd0};
    tbl[1]  = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b11010,32'h100,32'h18, 16'd0,16'd0};
    tbl[2]  = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00000,32'h100,32'h18, 16'd1,16'd1};
    tbl[3]  = '{0,0,1,4'd14,0,4'b0000,32'h40, 32'h200,5'b00000,32'h100,32'h18, 16'd1,16'd1};
    tbl[4]  = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b11110,32'h200,32'h48, 16'd1,16'd1};
    tbl[5]  = '{0,1,0,4'd14,0,4'b0000,32'h80, 32'h300,5'b00001,32'h200,32'h48, 16'd2,16'd2};
    tbl[6]  = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00000,32'h200,32'h48, 16'd2,16'd2};
    tbl[7]  = '{0,1,0,4'd1, 0,4'b0000,32'h100,32'h400,5'b00000,32'h200,32'h48, 16'd2,16'd2};
    tbl[8]  = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00010,32'h400,32'h108,16'd2,16'd2};
    tbl[9]  = '{0,1,1,4'd2, 1,4'b0010,32'h20, 32'h500,5'b00000,32'h400,32'h108,16'd3,16'd2};
    tbl[10] = '{0,0,0,4'd0, 1,4'b0000,32'h0,  32'h0,  5'b11110,32'h500,32'h28, 16'd3,16'd2};
    tbl[11] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00000,32'h500,32'h28, 16'd4,16'd3};
    tbl[12] = '{0,1,0,4'd9, 1,4'b1111,32'h30, 32'h600,5'b00000,32'h500,32'h28, 16'd4,16'd3};
    tbl[13] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00010,32'h600,32'h38, 16'd4,16'd3};
    tbl[14] = '{0,1,0,4'd15,0,4'b0000,32'h50, 32'h700,5'b00000,32'h600,32'h38, 16'd5,16'd3};
    tbl[15] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00010,32'h700,32'h58, 16'd5,16'd3};
    tbl[16] = '{0,1,0,4'd4, 0,4'b0000,32'h60, 32'h800,5'b00000,32'h700,32'h58, 16'd6,16'd3};
    tbl[17] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b11010,32'h800,32'h68, 16'd6,16'd3};
    tbl[18] = '{1,1,0,4'd14,0,4'b0000,32'h0,  32'h0,  5'b00000,32'h800,32'h68, 16'd7,16'd4};
    tbl[19] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00000,32'h800,32'h68, 16'd7,16'd4};
    tbl[20] = '{1,1,0,4'd14,0,4'b0000,32'h90, 32'h999,5'b00000,32'h800,32'h68, 16'd7,16'd4};
    tbl[21] = '{0,0,0,4'd0, 0,4'b0000,32'h0,  32'h0,  5'b00000,32'h800,32'h68, 16'd7,16'd4};

    reset = 1'b1;
    drive(0, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_all("reset", -1, 5'b00000, 32'h0, 32'h0, 16'd0, 16'd0);
    tick();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].stall, tbl[i].b, tbl[i].bl, tbl[i].cond,
            tbl[i].fwe, tbl[i].zncv, tbl[i].pc, tbl[i].tgt);
      #2;
      check_all("tbl", i, tbl[i].e_str, tbl[i].e_tgt, tbl[i].e_link,
                tbl[i].e_bc, tbl[i].e_tc);
      tick();
    end

    // stall held three cycles in RESOLVE
    drive(0, 1, 0, 4'd14, 0, 4'b0000, 32'h70, 32'h900);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 32'h0);
      #2;
      check_all("stall", k, 5'b00010, 32'h900, 32'h78, 16'd7, 16'd4);
      tick();
    end
    drive(0, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 32'h0);
    #2;
    check_all("unstall", 0, 5'b11010, 32'h900, 32'h78, 16'd7, 16'd4);
    tick();
    #2;
    check_all("dslot", 0, 5'b00000, 32'h900, 32'h78, 16'd8, 16'd5);
    tick();

    // reset asserted while in RESOLVE
    drive(0, 0, 1, 4'd14, 0, 4'b0000, 32'hA0, 32'hB00);
    tick();
    drive(0, 0, 0, 4'd0, 0, 4'b0000, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    check({"rst_in_resolve", ".strobes"}, 0, 32'(strobes()), 32'h0);
    tick();
    reset = 1'b0;
    #2;
    check_all("after_rst", 0, 5'b00000, 32'h0, 32'h0, 16'd0, 16'd0);
    tick();
    #2;
    check({"idle_after_rst", ".strobes"}, 0, 32'(strobes()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Sequences conditional branches in the decode/execute boundary of the pipeline. It holds the architectural ZNCV flag register, latches a branch from ID, and resolves its condition one cycle later against committed flags through an embedded condition evaluator. It then drives the PC redirect, the post-delay-slot flush and the branch-and-link writeback. It enforces the single delay slot and keeps branch and taken statistics.

## Interface
- ADDR_W, 32, width of PC, target and link address
- CNT_W, 16, width of statistics counters
- LINK_OFFSET, 8, byte offset added to the branch PC to form the link address (return past the delay slot)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- stall_in  in  1  pipeline stall; freezes FSM, flags and counters
- B_in  in  1  branch in ID
- BL_in  in  1  branch-and-link in ID
- I_Cond_in  in  4  condition code of the ID branch (EQ=0, NE=1, CS=2, CC=3, MI=4, PL=5, VS=6, VC=7, AL=14, NV=15; others never true)
- flags_we_in  in  1  EX-stage instruction updates flags this cycle
- Z_in, N_in, C_in, V_in  in  1 each  new flag values from the ALU
- pc_in  in  ADDR_W  PC of the ID instruction
- target_in  in  ADDR_W  computed branch target of the ID instruction
- pc_sel_out  out  1  select target_out as next PC
- target_out  out  ADDR_W  latched branch target
- flush_out  out  1  squash the instruction in IF (the one after the delay slot)
- link_we_out  out  1  write link register
- link_addr_out  out  ADDR_W  latched PC + LINK_OFFSET
- busy_out  out  1  high in RESOLVE
- ds_branch_err_out  out  1  one-cycle pulse: branch found in a delay slot and ignored
- branch_cnt_out  out  CNT_W  branches resolved
- taken_cnt_out  out  CNT_W  branches taken

## Operation
- Flag register {Z,N,C,V}: resets to 0. Loads the inputs when flags_we_in & ~stall_in, in any state.
- FSM states: IDLE, RESOLVE, DSLOT. Reset state is IDLE.
- IDLE:
  - (B_in|BL_in) & ~stall_in → latch I_Cond_in, BL_in, target_in and pc_in+LINK_OFFSET (mod 2^ADDR_W).
  - Go to RESOLVE.
  - If B_in and BL_in are both high, treat the branch as BL.
- RESOLVE, with cond_eval computed from the latched condition and the flag register:
  - stall_in=1: hold the state; all strobes are 0.
  - stall_in=0: branch_cnt increments.
  - If cond_eval, then pc_sel_out=1, flush_out=1, link_we_out=latched BL, and taken_cnt increments. Next state is DSLOT.
  - Else all strobes are 0 and the next state is IDLE.
- DSLOT: the delay-slot instruction is in ID.
  - Any B_in|BL_in with ~stall_in is ignored and pulses ds_branch_err_out.
  - ~stall_in → IDLE.
  - stall_in → hold.
- Not-taken branches have no delay-slot restriction. A branch in ID during RESOLVE is not latched, because ID holds the delay slot.
- Counters wrap modulo 2^CNT_W and reset to 0.
- Outputs at reset: all 1-bit outputs 0; target_out, link_addr_out and both counters 0.
- target_out and link_addr_out keep their latched values until the next latch.

## Timing
- Branch sampled in IDLE at cycle t. Resolution is combinational in cycle t+1 (RESOLVE).
- Flags written by the EX instruction at t are visible to the condition at t+1. There is no forwarding path; this one-cycle sequencing is the purpose of the block.
- pc_sel_out, flush_out and link_we_out are single-cycle pulses per taken branch. With stall they are deferred, never repeated.
- flags_we_in at t+1 (during RESOLVE) does not affect that resolution. It updates the register at the end of t+1.
- reset in any state → IDLE on the next edge, with no strobes in that cycle.
- Minimum spacing between two taken branches: 3 cycles (IDLE→RESOLVE→DSLOT→IDLE).

## Structure
- Shared package branch_pkg:
  - cond_t enum (EQ … NV codes above)
  - state_t {IDLE, RESOLVE, DSLOT}
  - Default LINK_OFFSET
- Sub-module cond_eval_unit: combinational condition evaluation. Inputs are the 4-bit condition and ZNCV; output is cond_eval.
- FSM, flag register, latches and counters live in branch_sequencer.

## Test plan
- Flags Z=1 written at t; B_in, cond EQ, target 0x100 at t → at t+1 pc_sel_out=1, flush_out=1, target_out=0x100, link_we_out=0; taken_cnt=1.
- BL_in, cond AL, pc_in 0x40 → at t+1 link_we_out=1, link_addr_out=0x48, pc_sel_out=1.
- B_in, cond NE with Z=1 → no strobes; back to IDLE at t+2; branch_cnt=1, taken_cnt=0.
- Taken branch, then B_in in DSLOT → ds_branch_err_out pulses and is not latched; branch_cnt unchanged.
- stall_in held 3 cycles in RESOLVE → strobes appear once, in the first unstalled cycle.
- reset asserted during RESOLVE → next cycle IDLE, all outputs 0, counters 0; condition code 9 with any flags → never taken.
